// File: rtl/computer_pkg.sv
// Shared definitions for the system bus: default bus widths and the RAM arbiter state encoding.
package computer_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_WAIT = 2'd1,
    VID_WAIT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/phi_edge_detect.sv
// Synchronous rising-edge detector for a divider phase signal.
// The history register always tracks the phase, so no edge is reported right after reset.
module phi_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic phi,
  output logic rise_c
);

  logic phi_q;

  // The reset preload and the normal update are the same thing: load the current phase.
  always_ff @(posedge clk) begin
    phi_q <= phi;
  end

  assign rise_c = phi & ~phi_q & ~reset;

endmodule

// File: rtl/phi_bus_arbiter.sv
// Shares one RAM port between the CPU (slot on each cpu_phi rise) and the video
// fetcher (slot on a vid_phi rise); all memory-side and return outputs are registered.
module phi_bus_arbiter
  import computer_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              cpu_phi,
  input  logic              vid_phi,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

  if (MEM_LAT < 1 || MEM_LAT > 2) begin : g_lat_check
    $error("phi_bus_arbiter: MEM_LAT must be 1 or 2");
  end

  arb_state_t        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              vid_pending, vid_pending_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n, cpu_rdata_n, vid_data_n;
  logic              mem_we_n, vid_valid_n;
  logic              cpu_rise_c, vid_rise_c;

  phi_edge_detect u_cpu_edge (
    .clk    (CLOCK_50),
    .reset  (reset),
    .phi    (cpu_phi),
    .rise_c (cpu_rise_c)
  );

  phi_edge_detect u_vid_edge (
    .clk    (CLOCK_50),
    .reset  (reset),
    .phi    (vid_phi),
    .rise_c (vid_rise_c)
  );

  // Next-state and registered-output logic; the CPU always wins an IDLE slot.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    vid_pending_n = (vid_pending | vid_rise_c) & vid_req;
    mem_addr_n    = mem_addr;
    mem_wdata_n   = mem_wdata;
    mem_we_n      = 1'b0;
    cpu_rdata_n   = cpu_rdata;
    vid_data_n    = vid_data;
    vid_valid_n   = 1'b0;

    unique case (state)
      IDLE: begin
        if (cpu_rise_c) begin
          mem_addr_n = cpu_addr;
          if (cpu_we) begin
            mem_we_n    = 1'b1;
            mem_wdata_n = cpu_wdata;
          end else begin
            state_n = CPU_WAIT;
            cnt_n   = '0;
          end
        end else if (vid_pending_n) begin
          mem_addr_n    = vid_addr;
          state_n       = VID_WAIT;
          cnt_n         = '0;
          vid_pending_n = 1'b0;
        end
      end
      CPU_WAIT: begin
        if (cnt == LAST_CNT) begin
          cpu_rdata_n = mem_rdata;
          state_n     = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      VID_WAIT: begin
        if (cnt == LAST_CNT) begin
          vid_data_n  = mem_rdata;
          vid_valid_n = 1'b1;
          state_n     = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      vid_pending <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      cpu_rdata   <= '0;
      vid_data    <= '0;
      vid_valid   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      vid_pending <= vid_pending_n;
      mem_addr    <= mem_addr_n;
      mem_wdata   <= mem_wdata_n;
      mem_we      <= mem_we_n;
      cpu_rdata   <= cpu_rdata_n;
      vid_data    <= vid_data_n;
      vid_valid   <= vid_valid_n;
    end
  end

  // Legal divider ratios never produce a CPU slot while an access is still in flight.
  cpu_rise_while_busy: assert property (
    @(posedge CLOCK_50) disable iff (reset) !(cpu_rise_c && (state != IDLE))
  );

endmodule
